// File: rtl/mc_controller_if.sv
// Shared instruction/data memory port between the multicycle controller and memory.
// The controller drives the request side; memory answers with mem_ready.
interface mc_controller_if;
  logic mem_req;
  logic mem_ready;
  logic MemWrite;
  logic AdrSrc;

  modport master (output mem_req, output MemWrite, output AdrSrc, input mem_ready);
  modport slave  (input mem_req, input MemWrite, input AdrSrc, output mem_ready);
endinterface

// File: rtl/mc_controller.sv
// Multicycle control unit: sequences each instruction over one shared memory port and holds NZCV.
// Build option: define NOWRITE_CMP_EN to decode CMP (1010) and TST (1000) as flag-only commands.
//
// state    | meaning
// FETCH    | read instruction at PC, latch IR and PC+4 on mem_ready
// DECODE   | PC+8 through ALU, pick the instruction class
// EXECR    | data-processing with register operand
// EXECI    | data-processing with immediate operand
// ALUWB    | write ALU result, update flags when S
// MEMADR   | compute load/store address
// MEMREAD  | load data access
// MEMWB    | write loaded data to register file
// MEMWRITE | store data access
// BRANCH   | conditional PC update
// FAULT    | undefined op or bus timeout, held until reset
module mc_controller #(
  parameter int ALUC_W  = 2,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [19:0]       Instr,
  input  logic [3:0]        ALUFlags,
  mc_controller_if.master   mem,
  output logic              IRWrite,
  output logic              PCWrite,
  output logic              RegWrite,
  output logic [1:0]        ResultSrc,
  output logic              ALUSrcA,
  output logic [1:0]        ALUSrcB,
  output logic [1:0]        ImmSrc,
  output logic [1:0]        RegSrc,
  output logic [ALUC_W-1:0] ALUControl,
  output logic              fault
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [ALUC_W-1:0] ALU_ADD = '0;
  localparam logic [ALUC_W-1:0] ALU_SUB = ALUC_W'(1);
  localparam logic [ALUC_W-1:0] ALU_AND = ALUC_W'(2);
  localparam logic [ALUC_W-1:0] ALU_ORR = ALUC_W'(3);
  localparam logic [ALUC_W-1:0] ALU_EOR = ALUC_W'(4);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXECR, S_EXECI, S_ALUWB, S_MEMADR,
    S_MEMREAD, S_MEMWB, S_MEMWRITE, S_BRANCH, S_FAULT
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   wait_q, wait_d;
  logic [3:0]         flags_q;
  logic               req_q, memwr_q, adr_q, regwr_q, brpc_q, srca_q, fault_q;
  logic [1:0]         res_q, srcb_q;
  logic [ALUC_W-1:0]  aluc_q;

  logic [3:0]         cond;
  logic [1:0]         op;
  logic [3:0]         cmd;
  logic               bit_i, bit_s;
  logic               cond_ex;
  logic               cmd_ok, cmd_arith, cmd_nowrite;
  logic [ALUC_W-1:0]  cmd_alu;
  logic               req_st, timed_out, fetch_hit;
  logic               unused_rd;

  assign cond      = Instr[19:16];
  assign op        = Instr[15:14];
  assign bit_i     = Instr[13];
  assign cmd       = Instr[12:9];
  assign bit_s     = Instr[8];
  assign unused_rd = ^Instr[7:0];

  always_comb begin
    logic n, z, c, v;
    {n, z, c, v} = flags_q;
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = ~z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = ~c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = ~n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = ~v;
      4'b1000: cond_ex = c & ~z;
      4'b1001: cond_ex = ~c | z;
      4'b1010: cond_ex = (n == v);
      4'b1011: cond_ex = (n != v);
      4'b1100: cond_ex = ~z & (n == v);
      4'b1101: cond_ex = z | (n != v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_comb begin
    cmd_ok      = 1'b1;
    cmd_alu     = ALU_ADD;
    cmd_arith   = 1'b0;
    cmd_nowrite = 1'b0;
    case (cmd)
      4'b0100: cmd_arith = 1'b1;
      4'b0010: begin cmd_alu = ALU_SUB; cmd_arith = 1'b1; end
      4'b0000: cmd_alu = ALU_AND;
      4'b1100: cmd_alu = ALU_ORR;
      4'b0001: begin
        if (ALUC_W >= 3) cmd_alu = ALU_EOR;
        else             cmd_ok  = 1'b0;
      end
`ifdef NOWRITE_CMP_EN
      4'b1010: begin cmd_alu = ALU_SUB; cmd_arith = 1'b1; cmd_nowrite = 1'b1; end
      4'b1000: begin cmd_alu = ALU_AND; cmd_nowrite = 1'b1; end
`endif
      default: cmd_ok = 1'b0;
    endcase
  end

  // A ready in the last allowed wait cycle still completes the access.
  assign req_st    = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
  assign timed_out = (TIMEOUT != 0) && req_st && !mem.mem_ready &&
                     (wait_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          2'b00:   state_d = !cmd_ok ? S_FAULT : (bit_i ? S_EXECI : S_EXECR);
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FAULT;
        endcase
      end
      S_EXECR,
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_MEMADR:   state_d = !cond_ex ? S_FETCH : (bit_s ? S_MEMREAD : S_MEMWRITE);
      S_MEMREAD:  if (mem.mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem.mem_ready) state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      default:    state_d = S_FAULT;
    endcase
    if (timed_out) state_d = S_FAULT;
  end

  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q)            wait_d = '0;
    else if (req_st && !mem.mem_ready) wait_d = wait_q + CNT_W'(1);
  end

  // Outputs are registered from the next state; reset values are the FETCH decode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      flags_q <= 4'b0000;
      req_q   <= 1'b1;
      memwr_q <= 1'b0;
      adr_q   <= 1'b0;
      regwr_q <= 1'b0;
      brpc_q  <= 1'b0;
      srca_q  <= 1'b1;
      srcb_q  <= 2'b10;
      res_q   <= 2'b10;
      aluc_q  <= ALU_ADD;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (state_q == S_ALUWB && bit_s && cond_ex) begin
        flags_q[3:2] <= ALUFlags[3:2];
        if (cmd_arith) flags_q[1:0] <= ALUFlags[1:0];
      end
      req_q   <= 1'b0;
      memwr_q <= 1'b0;
      adr_q   <= 1'b0;
      regwr_q <= 1'b0;
      brpc_q  <= 1'b0;
      srca_q  <= 1'b0;
      srcb_q  <= 2'b00;
      res_q   <= 2'b00;
      aluc_q  <= ALU_ADD;
      fault_q <= 1'b0;
      case (state_d)
        S_FETCH:    begin req_q <= 1'b1; srca_q <= 1'b1; srcb_q <= 2'b10; res_q <= 2'b10; end
        S_DECODE:   begin srca_q <= 1'b1; srcb_q <= 2'b10; end
        S_EXECR:    aluc_q <= cmd_alu;
        S_EXECI:    begin srcb_q <= 2'b01; aluc_q <= cmd_alu; end
        S_ALUWB:    begin aluc_q <= cmd_alu; regwr_q <= cond_ex & ~cmd_nowrite; end
        S_MEMADR:   srcb_q <= 2'b01;
        S_MEMREAD:  begin req_q <= 1'b1; adr_q <= 1'b1; end
        S_MEMWB:    begin res_q <= 2'b01; regwr_q <= 1'b1; end
        S_MEMWRITE: begin req_q <= 1'b1; memwr_q <= 1'b1; adr_q <= 1'b1; end
        S_BRANCH:   begin srcb_q <= 2'b01; res_q <= 2'b10; brpc_q <= cond_ex; end
        default:    fault_q <= 1'b1;
      endcase
    end
  end

  // IR/PC latch follows the same-cycle ready, so it cannot come from a register.
  assign fetch_hit    = reset && (state_q == S_FETCH) && mem.mem_ready;
  assign mem.mem_req  = req_q & reset;
  assign mem.MemWrite = memwr_q;
  assign mem.AdrSrc   = adr_q;
  assign IRWrite      = fetch_hit;
  assign PCWrite      = fetch_hit | brpc_q;
  assign RegWrite     = regwr_q;
  assign ResultSrc    = res_q;
  assign ALUSrcA      = srca_q;
  assign ALUSrcB      = srcb_q;
  assign ALUControl   = aluc_q;
  assign fault        = fault_q;
  assign ImmSrc       = op;
  assign RegSrc       = {op == 2'b01, op == 2'b10};

endmodule
